// File: rtl/ob_sorted_table_if.sv
// rtl/ob_sorted_table_if.sv - command, response and head bundle for ob_sorted_table
interface ob_sorted_table_if #(
  parameter int N       = 16,
  parameter int UID_W   = 32,
  parameter int QTY_W   = 16,
  parameter int PRICE_W = 20
);
  localparam int CNT_W = $clog2(N + 1);

  logic               cmd_vld;
  logic               cmd_rdy;
  logic [1:0]         cmd_op;
  logic [UID_W-1:0]   cmd_uid;
  logic [QTY_W-1:0]   cmd_qty;
  logic [PRICE_W-1:0] cmd_price;

  logic               rsp_vld;
  logic [2:0]         rsp_status;
  logic [UID_W-1:0]   rsp_uid;
  logic [QTY_W-1:0]   rsp_qty;
  logic [PRICE_W-1:0] rsp_price;

  logic               head_vld;
  logic [UID_W-1:0]   head_uid;
  logic [QTY_W-1:0]   head_qty;
  logic [PRICE_W-1:0] head_price;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  modport master (
    output cmd_vld, cmd_op, cmd_uid, cmd_qty, cmd_price,
    input  cmd_rdy, rsp_vld, rsp_status, rsp_uid, rsp_qty, rsp_price,
    input  head_vld, head_uid, head_qty, head_price, count, full, empty
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_uid, cmd_qty, cmd_price,
    output cmd_rdy, rsp_vld, rsp_status, rsp_uid, rsp_qty, rsp_price,
    output head_vld, head_uid, head_qty, head_price, count, full, empty
  );
endinterface

// File: rtl/ob_sorted_table.sv
// rtl/ob_sorted_table.sv - price-sorted order-book side table; Modify op enabled by OB_SORTED_TABLE_MODIFY_EN
module ob_sorted_table #(
  parameter int N       = 16,
  parameter int UID_W   = 32,
  parameter int QTY_W   = 16,
  parameter int PRICE_W = 20,
  parameter bit IS_BID  = 1'b1
) (
  input  logic             clk,
  input  logic             arst_n,
  ob_sorted_table_if.slave bus
);
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);
  localparam logic [PRICE_W-1:0] PRICE_INIT = IS_BID ? {PRICE_W{1'b0}} : {PRICE_W{1'b1}};

  localparam logic [1:0] OP_INS = 2'b00, OP_POP = 2'b01, OP_CAN = 2'b10;
  localparam logic [2:0] ST_OKAY = 3'b000, ST_REJECT = 3'b001, ST_CHIT = 3'b010,
                         ST_CMISS = 3'b011, ST_BADPOP = 3'b101;

  typedef enum logic {IDLE, CANCEL} state_t;

  state_t             state_q;
  logic               rdy_q;
  logic [UID_W-1:0]   uid_q   [N];
  logic [QTY_W-1:0]   qty_q   [N];
  logic [PRICE_W-1:0] price_q [N];
  logic [CNT_W-1:0]   count_q;
  logic [N-1:0]       match_q;
  logic [UID_W-1:0]   can_uid_q;

  logic               rsp_vld_q;
  logic [2:0]         rsp_status_q;
  logic [UID_W-1:0]   rsp_uid_q;
  logic [QTY_W-1:0]   rsp_qty_q;
  logic [PRICE_W-1:0] rsp_price_q;

  logic               accept, is_full, is_empty, can_hit;
  logic               do_ins, do_rm;
  logic [CNT_W-1:0]   ins_idx;
  logic [IDX_W-1:0]   can_idx, rm_idx;

  // rdy_q is only high in IDLE, so accept never fires during CANCEL
  assign accept   = bus.cmd_vld && rdy_q;
  assign is_full  = (count_q == CNT_W'(N));
  assign is_empty = (count_q == '0);
  assign can_hit  = |match_q;

`ifdef OB_SORTED_TABLE_MODIFY_EN
  logic [QTY_W:0] mod_diff;
  logic           mod_pos, mod_upd;
  assign mod_diff = {1'b0, qty_q[0]} - {1'b0, bus.cmd_qty};
  assign mod_pos  = !mod_diff[QTY_W] && (mod_diff != '0);
`endif

  // Insertion point: first valid entry strictly worse than the new price
  always_comb begin
    ins_idx = count_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (i < int'(count_q) &&
          (IS_BID ? (price_q[i] < bus.cmd_price) : (price_q[i] > bus.cmd_price)))
        ins_idx = CNT_W'(i);
    end
  end

  always_comb begin
    can_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (match_q[i]) can_idx = IDX_W'(i);
  end

  always_comb begin
    do_ins = 1'b0;
    do_rm  = 1'b0;
    rm_idx = '0;
`ifdef OB_SORTED_TABLE_MODIFY_EN
    mod_upd = 1'b0;
`endif
    if (state_q == CANCEL) begin
      do_rm  = can_hit;
      rm_idx = can_idx;
    end else if (accept) begin
      case (bus.cmd_op)
        OP_INS: do_ins = !is_full;
        OP_POP: do_rm  = !is_empty;
`ifdef OB_SORTED_TABLE_MODIFY_EN
        2'b11: begin
          mod_upd = !is_empty && mod_pos;
          do_rm   = !is_empty && !mod_pos;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b0;
      count_q      <= '0;
      match_q      <= '0;
      can_uid_q    <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_status_q <= '0;
      rsp_uid_q    <= '0;
      rsp_qty_q    <= '0;
      rsp_price_q  <= '0;
      for (int i = 0; i < N; i++) begin
        uid_q[i]   <= '0;
        qty_q[i]   <= '0;
        price_q[i] <= PRICE_INIT;
      end
    end else begin
      rsp_vld_q <= 1'b0;

      if (do_ins) begin
        for (int i = 1; i < N; i++) begin
          if (i > int'(ins_idx)) begin
            uid_q[i]   <= uid_q[i-1];
            qty_q[i]   <= qty_q[i-1];
            price_q[i] <= price_q[i-1];
          end
        end
        for (int i = 0; i < N; i++) begin
          if (i == int'(ins_idx)) begin
            uid_q[i]   <= bus.cmd_uid;
            qty_q[i]   <= bus.cmd_qty;
            price_q[i] <= bus.cmd_price;
          end
        end
        count_q <= count_q + CNT_W'(1);
      end else if (do_rm) begin
        for (int i = 0; i < N - 1; i++) begin
          if (i >= int'(rm_idx)) begin
            uid_q[i]   <= uid_q[i+1];
            qty_q[i]   <= qty_q[i+1];
            price_q[i] <= price_q[i+1];
          end
        end
        uid_q[N-1]   <= '0;
        qty_q[N-1]   <= '0;
        price_q[N-1] <= PRICE_INIT;
        count_q      <= count_q - CNT_W'(1);
      end
`ifdef OB_SORTED_TABLE_MODIFY_EN
      else if (mod_upd) qty_q[0] <= mod_diff[QTY_W-1:0];
`endif

      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            rsp_vld_q <= 1'b1;
            case (bus.cmd_op)
              OP_INS: begin
                rsp_status_q <= is_full ? ST_REJECT : ST_OKAY;
                rsp_uid_q    <= bus.cmd_uid;
                rsp_qty_q    <= bus.cmd_qty;
                rsp_price_q  <= bus.cmd_price;
              end
              OP_POP: begin
                rsp_status_q <= is_empty ? ST_BADPOP : ST_OKAY;
                rsp_uid_q    <= is_empty ? '0 : uid_q[0];
                rsp_qty_q    <= is_empty ? '0 : qty_q[0];
                rsp_price_q  <= is_empty ? '0 : price_q[0];
              end
              OP_CAN: begin
                rsp_vld_q <= 1'b0;
                rdy_q     <= 1'b0;
                state_q   <= CANCEL;
                can_uid_q <= bus.cmd_uid;
                for (int i = 0; i < N; i++)
                  match_q[i] <= (i < int'(count_q)) && (uid_q[i] == bus.cmd_uid);
              end
              default: begin
`ifdef OB_SORTED_TABLE_MODIFY_EN
                // Partial fill reports the new head; a full fill reports the popped original
                rsp_status_q <= is_empty ? ST_BADPOP : ST_OKAY;
                rsp_uid_q    <= is_empty ? '0 : uid_q[0];
                rsp_qty_q    <= is_empty ? '0 : (mod_pos ? mod_diff[QTY_W-1:0] : qty_q[0]);
                rsp_price_q  <= is_empty ? '0 : price_q[0];
`else
                rsp_status_q <= ST_REJECT;
                rsp_uid_q    <= bus.cmd_uid;
                rsp_qty_q    <= bus.cmd_qty;
                rsp_price_q  <= bus.cmd_price;
`endif
              end
            endcase
          end
        end
        CANCEL: begin
          state_q      <= IDLE;
          rdy_q        <= 1'b1;
          rsp_vld_q    <= 1'b1;
          rsp_status_q <= can_hit ? ST_CHIT : ST_CMISS;
          rsp_uid_q    <= can_hit ? uid_q[can_idx] : can_uid_q;
          rsp_qty_q    <= can_hit ? qty_q[can_idx] : '0;
          rsp_price_q  <= can_hit ? price_q[can_idx] : '0;
        end
      endcase
    end
  end

  assign bus.cmd_rdy    = rdy_q;
  assign bus.rsp_vld    = rsp_vld_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_uid    = rsp_uid_q;
  assign bus.rsp_qty    = rsp_qty_q;
  assign bus.rsp_price  = rsp_price_q;
  assign bus.head_vld   = !is_empty;
  assign bus.head_uid   = uid_q[0];
  assign bus.head_qty   = qty_q[0];
  assign bus.head_price = price_q[0];
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
endmodule

// File: tb/tb_ob_sorted_table.sv
// tb/tb_ob_sorted_table.sv - directed bench with a behavioural book model for bid and ask ob_sorted_table
module tb_ob_sorted_table;
  localparam int N = 4;
  localparam logic [1:0] INS = 2'b00, POP = 2'b01, CAN = 2'b10, MOD = 2'b11;
  localparam logic [2:0] OKAY = 3'b000, REJECT = 3'b001, CHIT = 3'b010, CMISS = 3'b011, BADPOP = 3'b101;

  typedef struct packed {
    logic [31:0] uid;
    logic [15:0] qty;
    logic [19:0] price;
  } ent_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  ob_sorted_table_if #(.N(N), .UID_W(32), .QTY_W(16), .PRICE_W(20)) bb ();
  ob_sorted_table_if #(.N(N), .UID_W(32), .QTY_W(16), .PRICE_W(20)) ab ();

  ob_sorted_table #(.N(N), .UID_W(32), .QTY_W(16), .PRICE_W(20), .IS_BID(1'b1))
    dut_bid (.clk(clk), .arst_n(arst_n), .bus(bb));
  ob_sorted_table #(.N(N), .UID_W(32), .QTY_W(16), .PRICE_W(20), .IS_BID(1'b0))
    dut_ask (.clk(clk), .arst_n(arst_n), .bus(ab));

  // Model: side 0 = bid, side 1 = ask
  ent_t        tbl [2][N];
  int          cnt [2];
  logic        e_rdy [2];
  logic        e_rv [2];
  logic [2:0]  e_st [2];
  ent_t        e_rsp [2];
  logic        pend [2];
  logic [31:0] pend_uid [2];

  int   n_vec = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t empty_slot(input int s);
    return {32'h0, 16'h0, (s == 0) ? 20'h00000 : 20'hFFFFF};
  endfunction

  // An existing entry stays ahead of a newcomer when its price is at least as good
  function automatic bit better_eq(input int s, input logic [19:0] have, input logic [19:0] incoming);
    return (s == 0) ? (have >= incoming) : (have <= incoming);
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      cnt[s] = 0; e_rdy[s] = 1'b0; e_rv[s] = 1'b0; e_st[s] = '0;
      e_rsp[s] = '0; pend[s] = 1'b0; pend_uid[s] = '0;
      for (int i = 0; i < N; i++) tbl[s][i] = empty_slot(s);
    end
  endtask

  task automatic m_remove(input int s, input int j);
    for (int i = j; i < cnt[s] - 1; i++) tbl[s][i] = tbl[s][i+1];
    tbl[s][cnt[s]-1] = empty_slot(s);
    cnt[s]--;
  endtask

  task automatic m_step(input int s, input logic vld, input logic [1:0] op, input ent_t c);
    int k;
    int j;
    e_rv[s] = 1'b0;
    if (pend[s]) begin
      j = -1;
      for (int i = 0; i < cnt[s]; i++)
        if (j < 0 && tbl[s][i].uid == pend_uid[s]) j = i;
      e_rv[s] = 1'b1;
      if (j >= 0) begin
        e_st[s] = CHIT; e_rsp[s] = tbl[s][j]; m_remove(s, j);
      end else begin
        e_st[s] = CMISS; e_rsp[s] = {pend_uid[s], 16'h0, 20'h0};
      end
      pend[s] = 1'b0;
      e_rdy[s] = 1'b1;
    end else begin
      if (vld && e_rdy[s]) begin
        e_rv[s] = 1'b1;
        case (op)
          INS: begin
            e_rsp[s] = c;
            if (cnt[s] == N) e_st[s] = REJECT;
            else begin
              k = 0;
              for (int i = 0; i < cnt[s]; i++) if (better_eq(s, tbl[s][i].price, c.price)) k++;
              for (int i = cnt[s]; i > k; i--) tbl[s][i] = tbl[s][i-1];
              tbl[s][k] = c; cnt[s]++; e_st[s] = OKAY;
            end
          end
          POP: begin
            if (cnt[s] == 0) begin e_st[s] = BADPOP; e_rsp[s] = '0; end
            else begin e_st[s] = OKAY; e_rsp[s] = tbl[s][0]; m_remove(s, 0); end
          end
          CAN: begin
            e_rv[s] = 1'b0; pend[s] = 1'b1; pend_uid[s] = c.uid;
          end
          default: begin
`ifdef OB_SORTED_TABLE_MODIFY_EN
            if (cnt[s] == 0) begin e_st[s] = BADPOP; e_rsp[s] = '0; end
            else if (int'(tbl[s][0].qty) > int'(c.qty)) begin
              tbl[s][0].qty = tbl[s][0].qty - c.qty; e_st[s] = OKAY; e_rsp[s] = tbl[s][0];
            end else begin
              e_st[s] = OKAY; e_rsp[s] = tbl[s][0]; m_remove(s, 0);
            end
`else
            e_st[s] = REJECT; e_rsp[s] = c;
`endif
          end
        endcase
      end
      e_rdy[s] = !pend[s];
    end
  endtask

  always @(posedge clk) begin
    if (!arst_n) m_reset();
    else begin
      m_step(0, bb.cmd_vld, bb.cmd_op, {bb.cmd_uid, bb.cmd_qty, bb.cmd_price});
      m_step(1, ab.cmd_vld, ab.cmd_op, {ab.cmd_uid, ab.cmd_qty, ab.cmd_price});
    end
  end

  task automatic cmp_side(input int s, input logic rdy, input logic rv, input logic [2:0] st, input ent_t r,
                          input logic hv, input ent_t h, input logic [2:0] c, input logic fu, input logic em);
    string p;
    p = (s == 0) ? "bid" : "ask";
    chk({p, "_cmd_rdy"}, rdy, e_rdy[s]);
    chk({p, "_rsp_vld"}, rv, e_rv[s]);
    if (e_rv[s]) begin
      chk({p, "_rsp_status"}, st, e_st[s]);
      chk({p, "_rsp_entry"}, r, e_rsp[s]);
    end
    chk({p, "_count"}, c, cnt[s]);
    chk({p, "_head_vld"}, hv, cnt[s] != 0);
    chk({p, "_full"}, fu, cnt[s] == N);
    chk({p, "_empty"}, em, cnt[s] == 0);
    if (cnt[s] != 0) chk({p, "_head"}, h, tbl[s][0]);
  endtask

  always @(negedge clk) begin
    if (chk_en && arst_n) begin
      cmp_side(0, bb.cmd_rdy, bb.rsp_vld, bb.rsp_status, {bb.rsp_uid, bb.rsp_qty, bb.rsp_price},
               bb.head_vld, {bb.head_uid, bb.head_qty, bb.head_price}, bb.count, bb.full, bb.empty);
      cmp_side(1, ab.cmd_rdy, ab.rsp_vld, ab.rsp_status, {ab.rsp_uid, ab.rsp_qty, ab.rsp_price},
               ab.head_vld, {ab.head_uid, ab.head_qty, ab.head_price}, ab.count, ab.full, ab.empty);
    end
  end

  task automatic drive(input int s, input logic [1:0] op, input logic [31:0] uid,
                       input logic [15:0] qty, input logic [19:0] price);
    if (s == 0) begin
      bb.cmd_vld = 1'b1; bb.cmd_op = op; bb.cmd_uid = uid; bb.cmd_qty = qty; bb.cmd_price = price;
    end else begin
      ab.cmd_vld = 1'b1; ab.cmd_op = op; ab.cmd_uid = uid; ab.cmd_qty = qty; ab.cmd_price = price;
    end
    @(negedge clk); #1;
  endtask

  task automatic idle();
    bb.cmd_vld = 1'b0;
    ab.cmd_vld = 1'b0;
  endtask

  task automatic chk_rsp(input string name, input int s, input logic [2:0] st, input ent_t e);
    if (s == 0) begin
      chk({name, "_vld"}, bb.rsp_vld, 1'b1);
      chk({name, "_status"}, bb.rsp_status, st);
      chk({name, "_entry"}, {bb.rsp_uid, bb.rsp_qty, bb.rsp_price}, e);
    end else begin
      chk({name, "_vld"}, ab.rsp_vld, 1'b1);
      chk({name, "_status"}, ab.rsp_status, st);
      chk({name, "_entry"}, {ab.rsp_uid, ab.rsp_qty, ab.rsp_price}, e);
    end
  endtask

  initial begin
    m_reset();
    idle();
    bb.cmd_op = '0; bb.cmd_uid = '0; bb.cmd_qty = '0; bb.cmd_price = '0;
    ab.cmd_op = '0; ab.cmd_uid = '0; ab.cmd_qty = '0; ab.cmd_price = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bid_count", bb.count, 0);
    chk("rst_bid_rdy", bb.cmd_rdy, 0);
    chk("rst_bid_rsp_vld", bb.rsp_vld, 0);
    chk("rst_bid_head_vld", bb.head_vld, 0);
    chk("rst_bid_empty", bb.empty, 1);
    chk("rst_bid_full", bb.full, 0);
    chk("rst_bid_head", {bb.head_uid, bb.head_qty, bb.head_price}, 68'h0);
    chk("rst_ask_count", ab.count, 0);
    chk("rst_ask_rdy", ab.cmd_rdy, 0);
    arst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("rdy_after_release", bb.cmd_rdy, 1);

    drive(0, POP, 0, 0, 0); idle();
    chk_rsp("empty_pop", 0, BADPOP, '0);
    chk("empty_pop_head_vld", bb.head_vld, 0);
    chk("empty_pop_count", bb.count, 0);

    drive(0, INS, 1, 10, 20'h00100);
    chk_rsp("ins_uid1", 0, OKAY, {32'd1, 16'd10, 20'h00100});
    drive(0, INS, 2, 5, 20'h00200);
    chk_rsp("ins_uid2", 0, OKAY, {32'd2, 16'd5, 20'h00200});
    chk("ins_uid2_head", bb.head_uid, 2);
    drive(0, INS, 3, 7, 20'h00100); idle();
    chk_rsp("ins_uid3", 0, OKAY, {32'd3, 16'd7, 20'h00100});
    chk("ins3_head", bb.head_uid, 2);
    chk("ins3_count", bb.count, 3);

    drive(0, INS, 4, 1, 20'h00050);
    drive(0, INS, 9, 3, 20'h00300); idle();
    chk_rsp("ins_full", 0, REJECT, {32'd9, 16'd3, 20'h00300});
    chk("ins_full_count", bb.count, 4);
    chk("ins_full_flag", bb.full, 1);

    drive(0, POP, 0, 0, 0);
    chk_rsp("pop1", 0, OKAY, {32'd2, 16'd5, 20'h00200});
    chk("pop1_full", bb.full, 0);
    drive(0, POP, 0, 0, 0);
    chk_rsp("pop2", 0, OKAY, {32'd1, 16'd10, 20'h00100});
    drive(0, POP, 0, 0, 0);
    chk_rsp("pop3", 0, OKAY, {32'd3, 16'd7, 20'h00100});
    drive(0, POP, 0, 0, 0); idle();
    chk_rsp("pop4", 0, OKAY, {32'd4, 16'd1, 20'h00050});

    drive(1, INS, 32'h11, 8, 20'h00300);
    drive(1, INS, 32'h22, 4, 20'h00150); idle();
    chk("ask_head_price", ab.head_price, 20'h00150);
    drive(1, CAN, 32'h22, 0, 0); idle();
    chk("cancel_rdy_low", ab.cmd_rdy, 0);
    chk("cancel_no_early_rsp", ab.rsp_vld, 0);
    @(negedge clk); #1;
    chk_rsp("cancel_hit", 1, CHIT, {32'h22, 16'd4, 20'h00150});
    chk("cancel_hit_head", ab.head_price, 20'h00300);
    drive(1, CAN, 32'hDEAD, 0, 0); idle();
    @(negedge clk); #1;
    chk_rsp("cancel_miss", 1, CMISS, {32'hDEAD, 16'd0, 20'h0});

    drive(1, INS, 32'h33, 2, 20'h00300);
    drive(1, POP, 0, 0, 0); idle();
    chk_rsp("ask_time_prio", 1, OKAY, {32'h11, 16'd8, 20'h00300});
    chk("ask_time_prio_head", ab.head_uid, 32'h33);
    drive(1, CAN, 0, 0, 0); idle();
    @(negedge clk); #1;
    chk_rsp("cancel_invalid_slot", 1, CMISS, '0);
    chk("cancel_invalid_count", ab.count, 1);

    drive(0, INS, 5, 10, 20'h00100);
    drive(0, MOD, 0, 4, 0);
`ifdef OB_SORTED_TABLE_MODIFY_EN
    chk_rsp("mod_partial", 0, OKAY, {32'd5, 16'd6, 20'h00100});
    chk("mod_partial_head_qty", bb.head_qty, 6);
    drive(0, MOD, 0, 6, 0);
    chk_rsp("mod_full", 0, OKAY, {32'd5, 16'd6, 20'h00100});
    chk("mod_full_count", bb.count, 0);
    drive(0, MOD, 0, 1, 0); idle();
    chk_rsp("mod_empty", 0, BADPOP, '0);
`else
    idle();
    chk_rsp("mod_disabled", 0, REJECT, {32'd0, 16'd4, 20'h0});
    chk("mod_disabled_head_qty", bb.head_qty, 10);
    drive(0, POP, 0, 0, 0); idle();
`endif

    drive(1, CAN, 32'h33, 0, 0); idle();
    arst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_cancel_rsp", ab.rsp_vld, 0);
    chk("rst_mid_cancel_count", ab.count, 0);
    chk("rst_mid_cancel_rdy", ab.cmd_rdy, 0);
    @(negedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk); #1;
    chk("rdy_after_mid_reset", ab.cmd_rdy, 1);
    chk("no_rsp_after_mid_reset", ab.rsp_vld, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ob_sorted_table.md
Name: ob_sorted_table

Overview:
- Parametrised, price-sorted order-book side table: holds up to N resting orders (uid, quantity, price) in priority order, with the best entry at index 0.
- One instance per side. IS_BID=1 sorts by descending price (bid book); IS_BID=0 sorts by ascending price (ask book).
- Sits between the command decoder and the matching engine: accepts insert, pop-top and cancel commands, and always presents the current head to the matcher.

Parameters:
- N, 16, table depth in entries (N >= 2).
- UID_W, 32, order uid width.
- QTY_W, 16, quantity width.
- PRICE_W, 20, price width (packed BCD, 5 digits).
- IS_BID, 1, 1 = descending sort (bid book), 0 = ascending sort (ask book).

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; a command is accepted when cmd_vld & cmd_rdy
- cmd_op  in  2  00 Insert, 01 Pop, 10 Cancel, 11 Modify (optional feature)
- cmd_uid  in  UID_W  uid to insert or cancel
- cmd_qty  in  QTY_W  quantity (Insert/Modify)
- cmd_price  in  PRICE_W  price (Insert)
- rsp_vld  out  1  response valid, single-cycle pulse, no backpressure
- rsp_status  out  3  000 Okay, 001 Reject, 010 CancelHit, 011 CancelMiss, 101 BadPop
- rsp_uid / rsp_qty / rsp_price  out  UID_W / QTY_W / PRICE_W  affected entry
- head_vld  out  1  table non-empty
- head_uid / head_qty / head_price  out  UID_W / QTY_W / PRICE_W  entry at index 0, registered
- count  out  $clog2(N+1)  occupied entries
- full / empty  out  1  count==N / count==0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - count=0, empty=1, full=0, head_vld=0, rsp_vld=0, rsp_* fields=0.
  - Every entry holds uid=0, qty=0, price = PRICE_MIN (bid) or PRICE_MAX (ask).
  - head_* reflects entry 0; cmd_rdy=0 while arst_n is low, 1 in IDLE.
- Price compare: unsigned binary compare on the packed-BCD price (valid because digits are packed most significant first).
- FSM states: IDLE, CANCEL.
- Insert (IDLE, accepted cycle T):
  - If not full: compute the insertion index k = first index whose price is strictly worse than cmd_price. Equal prices go behind existing entries (time priority).
  - Shift entries k..count-1 down by one, write the new entry at k, count+1.
  - rsp_vld at T+1 with Okay and the inserted fields; head_* and count also update at T+1.
  - If full: table unchanged; Reject at T+1 echoing the command fields.
- Pop (IDLE, accepted T):
  - If non-empty: response at T+1 is Okay carrying the old head. Entries shift up by one; the vacated tail slot gets the init value; count-1.
  - If empty: BadPop, rsp fields zero.
- Cancel (accepted T):
  - T: go to CANCEL, latch the match vector over valid entries (uid compare); cmd_rdy=0 at T+1.
  - T+1: if any match, remove the lowest matching index j. Entries j+1.. shift up, count-1, response CancelHit with the removed entry. If no match: CancelMiss, rsp_uid=cmd_uid, qty/price 0. Then return to IDLE.
  - rsp_vld at T+2.
  - Uid uniqueness among resting entries is a caller requirement; on duplicates the closest-to-head entry is removed.
- Throughput: Insert/Pop back-to-back one per cycle. Cancel occupies 2 cycles.
- Invalid entries (index >= count) never match a cancel and are never reported.
- Reset mid-cancel: FSM to IDLE, no response is issued, table cleared.

Optional Feature:
- Macro: OB_SORTED_TABLE_MODIFY_EN.
- Enabled: op 11 Modify (partial fill) subtracts cmd_qty from head_qty; 1-cycle latency, response at T+1.
  - Result > 0: head_qty updated in place, Okay with the new head.
  - Result <= 0 (17-bit signed arithmetic): head popped, Okay with the old head and rsp_qty = original quantity.
  - Empty table: BadPop.
- Disabled: op 11 returns Reject at T+1; table unchanged.

Test Plan:
- Bid, N=4: insert (uid1, q10, p00100), (uid2, q5, p00200), (uid3, q7, p00100) -> head uid2; order uid2, uid1, uid3; count=3; each response Okay one cycle after accept.
- Fill to 4, then insert uid9 -> Reject at T+1, count stays 4, full=1; then Pop -> Okay with the old head, full=0.
- Ask: insert p00300, p00150 -> head price 00150; Cancel uid of p00150 -> cmd_rdy low one cycle, CancelHit at T+2, head price 00300; Cancel uid 0xDEAD -> CancelMiss.
- Pop on empty after reset -> BadPop, head_vld=0, count=0.
- Assert arst_n low during the CANCEL state -> no rsp_vld, count=0, cmd_rdy=1 one cycle after release.
- MODIFY_EN: head q10, Modify q4 -> head_qty 6; Modify q6 -> head popped, rsp_qty=6; without the macro, Modify -> Reject.
